// File: rtl/muldiv_seq_ctrl_if.sv
// Request/response handshake bundle for the iterative mul/div sequencer.
// master = execute stage, slave = sequencer.
interface muldiv_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// RV32M mul/div sequencer, 1 bit/cycle; result XLEN+2 edges after accept (2 for fast specials).
// Backpressure: one op at a time, req_ready only in IDLE; result held in DONE until resp_ready.
module muldiv_seq_ctrl #(
  parameter int XLEN         = 32,
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  muldiv_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, mb_q, mb_d;
  logic [XLEN-1:0] acc_q, acc_d, mq_q, mq_d, resp_data_q, resp_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  logic            accept, is_div, is_rem, sgn_a, sgn_b, a_s, b_s;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, quo, rem, fix_res;
  logic [XLEN:0]   add_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;

  assign accept   = bus.req_valid && bus.req_ready;
  assign is_div   = op_q[2];
  assign is_rem   = op_q[1];
  assign sgn_a    = is_div ? !op_q[0] : (op_q[1] ^ op_q[0]);
  assign sgn_b    = is_div ? !op_q[0] : (op_q[1:0] == 2'b01);
  assign a_s      = sgn_a & a_q[XLEN-1];
  assign b_s      = sgn_b & b_q[XLEN-1];
  assign abs_a    = a_s ? -a_q : a_q;
  assign abs_b    = b_s ? -b_q : b_q;
  assign div_zero = (b_q == '0);
  assign div_ovf  = !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
  assign special  = is_div && (div_zero || div_ovf);

  // Engine: {acc,mq} is the product shift pair, or remainder/quotient-dividend pair.
  assign add_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mb_q} : '0);
  assign div_shift = {acc_q, mq_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mb_q};

  assign prod = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
  assign quo  = neg_q ? -mq_q : mq_q;
  assign rem  = neg_q ? -acc_q : acc_q;

  always_comb begin
    fix_res = '0;
    if (is_div) begin
      if (div_zero)      fix_res = is_rem ? a_q : '1;
      else if (div_ovf)  fix_res = is_rem ? '0 : MIN_NEG;
      else               fix_res = is_rem ? rem : quo;
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      // Specials skip the iterations; FIX still selects the architectural value.
      S_PREP: state_d = (SPECIAL_FAST && special) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) && !flush;
    bus.resp_valid = (state_q == S_DONE);
    bus.resp_data  = resp_data_q;
    busy           = (state_q != S_IDLE);
  end

  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = bus.req_op;
          a_d  = bus.req_a;
          b_d  = bus.req_b;
        end
      end
      S_PREP: begin
        mb_d  = abs_b;
        mq_d  = abs_a;
        acc_d = '0;
        cnt_d = '0;
        neg_d = (is_div && is_rem) ? a_s : (a_s ^ b_s);
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            mq_d  = {mq_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_shift[XLEN-1:0];
            mq_d  = {mq_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {acc_d, mq_d} = {add_sum, mq_q[XLEN-1:1]};
        end
      end
      S_FIX: resp_data_d = fix_res;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      resp_data_q <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench: identical stimulus to a fast-special and a full-latency sequencer.
module tb_muldiv_seq_ctrl;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_ready = 1'b0;
  logic        f_busy, s_busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  muldiv_seq_ctrl_if #(.XLEN(32)) f_if ();
  muldiv_seq_ctrl_if #(.XLEN(32)) s_if ();

  assign f_if.req_valid  = req_valid;
  assign f_if.req_op     = req_op;
  assign f_if.req_a      = req_a;
  assign f_if.req_b      = req_b;
  assign f_if.resp_ready = resp_ready;
  assign s_if.req_valid  = req_valid;
  assign s_if.req_op     = req_op;
  assign s_if.req_a      = req_a;
  assign s_if.req_b      = req_b;
  assign s_if.resp_ready = resp_ready;

  muldiv_seq_ctrl #(.XLEN(32), .SPECIAL_FAST(1'b1)) u_fast (
    .clk(clk), .rst(rst), .flush(flush), .busy(f_busy), .bus(f_if.slave)
  );
  muldiv_seq_ctrl #(.XLEN(32), .SPECIAL_FAST(1'b0)) u_slow (
    .clk(clk), .rst(rst), .flush(flush), .busy(s_busy), .bus(s_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request; returns just after the accepting edge E0.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  // Edge index (after E0) at which each DUT first shows resp_valid; 0 if never within budget.
  task automatic wait_both(output int ef, output int es);
    ef = 0;
    es = 0;
    for (int e = 1; e <= 40 && (ef == 0 || es == 0); e++) begin
      @(posedge clk);
      #1;
      if (ef == 0 && f_if.resp_valid) ef = e;
      if (es == 0 && s_if.resp_valid) es = e;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat_f, input int lat_s);
    int ef, es;
    send(op, a, b);
    wait_both(ef, es);
    chk({tag, "_lat_fast"}, 32'(ef), 32'(lat_f));
    chk({tag, "_lat_slow"}, 32'(es), 32'(lat_s));
    chk({tag, "_data_fast"}, f_if.resp_data, exp);
    chk({tag, "_data_slow"}, s_if.resp_data, exp);
    consume();
    chk({tag, "_idle_after"}, {30'd0, f_busy, s_busy}, 32'd0);
  endtask

  initial begin
    int ef, es, rises;
    logic stable;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_busy", {30'd0, f_busy, s_busy}, 32'd0);
    chk("reset_resp_valid", {30'd0, f_if.resp_valid, s_if.resp_valid}, 32'd0);
    chk("reset_resp_data", f_if.resp_data | s_if.resp_data, 32'd0);
    chk("reset_req_ready", {30'd0, f_if.req_ready, s_if.req_ready}, 32'd3);

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34, 34);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34, 34);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34);

    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 34);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 34);

    run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 34);
    run_op("rem_m7_0", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, 34);
    run_op("divu_0_0", DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 2, 34);

    run_op("mul_m2_3", MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 34, 34);
    run_op("mulh_m2_3", MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34, 34);
    run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 34);
    run_op("mulhsu_m1_2", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 34);
    run_op("mulh_pos", MULH, 32'h4000_0000, 32'd4, 32'h0000_0001, 34, 34);

    // Flush during the 10th CALC cycle, then a new op straight after.
    send(DIVU, 32'd50, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {30'd0, f_busy, s_busy}, 32'd0);
    chk("flush_resp_valid", {30'd0, f_if.resp_valid, s_if.resp_valid}, 32'd0);
    run_op("divu_9_3_post_flush", DIVU, 32'd9, 32'd3, 32'd3, 34, 34);

    // Flush in IDLE blocks a simultaneous request.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = DIVU;
    req_a     = 32'd8;
    req_b     = 32'd2;
    #1;
    chk("flush_idle_req_ready", {30'd0, f_if.req_ready, s_if.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_idle_not_accepted", {30'd0, f_busy, s_busy}, 32'd0);

    // Result held while the consumer stalls.
    send(MUL, 32'd7, 32'd6);
    wait_both(ef, es);
    chk("hold_lat_slow", 32'(es), 32'd34);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      stable = stable && f_if.resp_valid && s_if.resp_valid &&
               (f_if.resp_data == 32'd42) && (s_if.resp_data == 32'd42);
    end
    chk("hold_stable", {31'd0, stable}, 32'd1);
    consume();

    // Reset mid-CALC abandons the op.
    send(DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_busy", {30'd0, f_busy, s_busy}, 32'd0);
    chk("midrst_resp_valid", {30'd0, f_if.resp_valid, s_if.resp_valid}, 32'd0);
    chk("midrst_resp_data", f_if.resp_data | s_if.resp_data, 32'd0);
    chk("midrst_req_ready", {30'd0, f_if.req_ready, s_if.req_ready}, 32'd3);
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (f_if.resp_valid || s_if.resp_valid) rises++;
    end
    chk("midrst_no_resp", 32'(rises), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
